// File: rtl/seq_divider.sv
// Restoring divider, signed/unsigned, one quotient bit per cycle; done 33 cycles after start (1 for divide-by-zero).
// No backpressure: start is honoured only in IDLE and ignored while busy or in the DONE cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_lt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic             w_last;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

  // r_quo starts as the dividend magnitude and fills with quotient bits from the LSB.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_lt      = w_diff[WIDTH];
  assign w_rem_nxt = w_lt ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_lt};
  assign w_quo_fin = r_qneg ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fin = r_rneg ? -w_rem_nxt : w_rem_nxt;
  assign w_last    = (r_cnt == 6'(WIDTH-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              r_quotient  <= '1;
              r_remainder <= dividend;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_quotient  <= w_quo_fin;
            r_remainder <= w_rem_fin;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed/unsigned results, divide-by-zero, overflow, busy and reset handling.
module tb_seq_divider;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int tests;
  int fails;
  int lat;
  int bcnt;
  int early;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents operands in cycle T, then counts cycles until done (lat) and busy-high cycles on the way.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    l = 0; bc = 0;
    do begin
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
      l++;
      if (busy) bc++;
    end while (!done && l < 100);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem",  remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, lat, bcnt);
    check("u100_7_lat",  lat, 32'd33);
    check("u100_7_busy", bcnt, 32'd33);
    check("u100_7_q",    quotient, 32'd14);
    check("u100_7_r",    remainder, 32'd2);
    @(negedge clk);
    check("u100_7_done_pulse", {31'd0, done}, 32'd0);
    check("u100_7_idle",       {31'd0, busy}, 32'd0);
    check("u100_7_hold_q",     quotient, 32'd14);

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("s_m7_2_lat", lat, 32'd33);
    check("s_m7_2_q",   quotient, 32'hFFFF_FFFD);
    check("s_m7_2_r",   remainder, 32'hFFFF_FFFF);

    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("u_m7_2_q", quotient, 32'h7FFF_FFFC);
    check("u_m7_2_r", remainder, 32'd1);

    run_div(1'b0, 32'h1234_5678, 32'd0, lat, bcnt);
    check("u_div0_lat",  lat, 32'd1);
    check("u_div0_busy", bcnt, 32'd1);
    check("u_div0_q",    quotient, 32'hFFFF_FFFF);
    check("u_div0_r",    remainder, 32'h1234_5678);

    run_div(1'b1, 32'h1234_5678, 32'd0, lat, bcnt);
    check("s_div0_lat", lat, 32'd1);
    check("s_div0_q",   quotient, 32'hFFFF_FFFF);
    check("s_div0_r",   remainder, 32'h1234_5678);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check("ovf_lat", lat, 32'd33);
    check("ovf_q",   quotient, 32'h8000_0000);
    check("ovf_r",   remainder, 32'd0);

    // Busy handling: restarts at T+10 and in the DONE cycle T+33 must be dropped.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    early = 0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c < 33 && done) early++;
      if (c == 10) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      end
      if (c == 33) begin
        check("bsy_done_t33", {31'd0, done}, 32'd1);
        check("bsy_q_t33",    quotient, 32'd14);
        check("bsy_r_t33",    remainder, 32'd2);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
      end
    end
    check("bsy_no_early_done", early, 32'd0);
    @(negedge clk);
    check("bsy_t34_done", {31'd0, done}, 32'd0);
    check("bsy_t34_busy", {31'd0, busy}, 32'd0);
    check("bsy_t34_q",    quotient, 32'd14);
    check("bsy_t34_r",    remainder, 32'd2);
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    check("bsy_t34_lat", lat, 32'd33);
    check("bsy_t34_q2",  quotient, 32'd10);
    check("bsy_t34_r2",  remainder, 32'd0);

    // Reset mid-run: outputs clear at once and the aborted operation never signals done.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q",    quotient, 32'd0);
    check("mid_rst_r",    remainder, 32'd0);
    early = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) early++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) early++;
    end
    check("mid_rst_no_done", early, 32'd0);

    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bcnt);
    check("post_rst_lat", lat, 32'd33);
    check("post_rst_q",   quotient, 32'hFFFF_FFFF);
    check("post_rst_r",   remainder, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
